// File: rtl/filter_pkg.sv
// Shared encodings for the window filter: filter modes, controller states and
// the ceiling-log2 helper used to size the accumulator and counters.
package filter_pkg;

  localparam logic [1:0] MODE_MEAN   = 2'd0;
  localparam logic [1:0] MODE_MAX    = 2'd1;
  localparam logic [1:0] MODE_MIN    = 2'd2;
  localparam logic [1:0] MODE_CENTRE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DIV   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider by a constant: one quotient bit per cycle, ACC_W cycles.
// done and quotient are valid combinationally during the final step.
module serial_divider
  import filter_pkg::*;
#(
  parameter int ACC_W   = 17,
  parameter int Q_W     = 10,
  parameter int DIVISOR = 81
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CNT_W = clog2(ACC_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ACC_W - 1);
  localparam logic [ACC_W:0]   DIV_EXT   = (ACC_W + 1)'(DIVISOR);

  logic [ACC_W:0]   rem_q;
  logic [ACC_W:0]   rem_n;
  logic [ACC_W:0]   shifted;
  logic [ACC_W:0]   diff;
  logic [ACC_W-1:0] quo_q;
  logic [ACC_W-1:0] quo_n;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             q_bit;

  // The remainder never reaches the divisor, so its top bit stays clear; it
  // still feeds the compare so a wider remainder would divide correctly.
  always_comb begin
    shifted = {rem_q[ACC_W-1:0], quo_q[ACC_W-1]};
    diff    = shifted - DIV_EXT;
    q_bit   = rem_q[ACC_W] || (shifted >= DIV_EXT);
    rem_n   = q_bit ? diff : shifted;
    quo_n   = {quo_q[ACC_W-2:0], q_bit};
  end

  assign done     = run_q && (cnt_q == LAST_STEP);
  assign quotient = quo_n[Q_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clear) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/window_filter.sv
// Square-window pixel filter: folds LANES taps per beat into a mean, max, min
// or centre result, dividing the sum serially for the rounded mean.
module window_filter
  import filter_pkg::*;
#(
  parameter int PIX_W = 10,
  parameter int WIN   = 9,
  parameter int LANES = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       refresh,
  input  logic [WIN*WIN*PIX_W-1:0]   data_bus,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIX_W-1:0]           out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int N      = WIN * WIN;
  localparam int BEATS  = N / LANES;
  localparam int ACC_W  = PIX_W + clog2(N);
  localparam int BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int CENTRE = (N - 1) / 2;
  localparam logic [ACC_W-1:0]  HALF_N    = ACC_W'(N / 2);
  localparam logic [ACC_W-1:0]  PIX_MAX   = {{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t               state_q;
  state_t               state_d;
  logic [N*PIX_W-1:0]   win_q;
  logic [1:0]           mode_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_fold;
  logic [PIX_W-1:0]     tap;
  logic [ACC_W-1:0]     tap_ext;
  logic [BEAT_W-1:0]    beat_q;
  logic                 last_beat;
  logic                 accept;
  logic                 div_start;
  logic                 div_done;
  logic [PIX_W-1:0]     div_quotient;
  logic [PIX_W-1:0]     centre_tap;

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign last_beat  = (beat_q == LAST_BEAT);
  assign accept     = in_ready && in_valid && !refresh;
  assign div_start  = (state_q == ST_ACCUM) && last_beat && (mode_q == MODE_MEAN) && !refresh;
  assign centre_tap = win_q[CENTRE*PIX_W +: PIX_W];

  // One beat's worth of taps folded onto the running accumulator.
  always_comb begin
    acc_fold = acc_q;
    tap      = '0;
    tap_ext  = '0;
    for (int l = 0; l < LANES; l++) begin
      tap     = win_q[(int'(beat_q) * LANES + l) * PIX_W +: PIX_W];
      tap_ext = {{(ACC_W-PIX_W){1'b0}}, tap};
      case (mode_q)
        MODE_MEAN: acc_fold = acc_fold + tap_ext;
        MODE_MAX:  if (tap_ext > acc_fold) acc_fold = tap_ext;
        MODE_MIN:  if (tap_ext < acc_fold) acc_fold = tap_ext;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (refresh) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (in_valid) state_d = ST_ACCUM;
        ST_ACCUM: if (last_beat) state_d = (mode_q == MODE_MEAN) ? ST_DIV : ST_DONE;
        ST_DIV:   if (div_done) state_d = ST_DONE;
        ST_DONE:  if (out_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The result loads on the same edge that enters DONE, so it is already
  // stable when out_valid first reads high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      mode_q <= MODE_MEAN;
      acc_q  <= '0;
      beat_q <= '0;
      out    <= '0;
    end else begin
      if (refresh) begin
        acc_q  <= '0;
        beat_q <= '0;
      end else if (accept) begin
        win_q  <= data_bus;
        mode_q <= mode;
        acc_q  <= (mode == MODE_MIN) ? PIX_MAX : '0;
        beat_q <= '0;
      end else if (state_q == ST_ACCUM) begin
        acc_q  <= acc_fold;
        beat_q <= beat_q + BEAT_W'(1);
      end

      if (refresh) begin
        out <= '0;
      end else if ((state_q == ST_ACCUM) && last_beat && (mode_q != MODE_MEAN)) begin
        out <= (mode_q == MODE_CENTRE) ? centre_tap : acc_fold[PIX_W-1:0];
      end else if ((state_q == ST_DIV) && div_done) begin
        out <= div_quotient;
      end
    end
  end

  serial_divider #(
    .ACC_W   (ACC_W),
    .Q_W     (PIX_W),
    .DIVISOR (N)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .clear    (refresh),
    .start    (div_start),
    .dividend (acc_fold + HALF_N),
    .done     (div_done),
    .quotient (div_quotient)
  );

endmodule

// File: tb/tb_window_filter.sv
// Directed bench for window_filter: every filter mode, latency, back-pressure,
// refresh and asynchronous reset behaviour against hand-computed results.
module tb_window_filter;

  localparam int PIX_W = 10;
  localparam int WIN   = 9;
  localparam int LANES = 9;
  localparam int N     = WIN * WIN;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               refresh = 1'b0;
  logic [N*PIX_W-1:0] data_bus = '0;
  logic [1:0]         mode = 2'd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PIX_W-1:0]   out;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               busy;

  logic [N*PIX_W-1:0] ramp;
  logic [N*PIX_W-1:0] ones;
  logic [N*PIX_W-1:0] zeros;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  window_filter #(
    .PIX_W (PIX_W),
    .WIN   (WIN),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .refresh   (refresh),
    .data_bus  (data_bus),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Offers one window, scrambles the inputs after acceptance, then counts
  // cycles until out_valid (capped so a stuck DUT cannot hang the run).
  task automatic send_window(input logic [N*PIX_W-1:0] d, input logic [1:0] m,
                             output int lat, output logic [PIX_W-1:0] res,
                             output logic rdy_after);
    data_bus = d;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    data_bus  = ~d;
    mode      = m ^ 2'b01;
    rdy_after = in_ready;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out !== 10'd0) begin bad++; $display("[TB] FAIL reset_out got=%0d want=0", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_mean_ramp();
    int lat; logic [PIX_W-1:0] res; logic rdy;
    send_window(ramp, 2'd0, lat, res, rdy);
    total++; if (rdy !== 1'b0) begin bad++; $display("[TB] FAIL mean_in_ready_after_accept got=%b want=0", rdy); end
    total++; if (lat !== 26) begin bad++; $display("[TB] FAIL mean_latency got=%0d want=26", lat); end
    total++; if (res !== 10'd40) begin bad++; $display("[TB] FAIL mean_ramp got=%0d want=40", res); end
    take_output();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mean_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
    total++; if (out !== 10'd40) begin bad++; $display("[TB] FAIL mean_hold got=%0d want=40", out); end
  endtask

  task automatic test_modes_ramp();
    int lat; logic [PIX_W-1:0] res; logic rdy;
    logic [PIX_W-1:0] want [1:3];
    want[1] = 10'd80; want[2] = 10'd0; want[3] = 10'd40;
    for (int m = 1; m <= 3; m++) begin
      send_window(ramp, 2'(m), lat, res, rdy);
      total++; if (lat !== 9) begin bad++; $display("[TB] FAIL mode%0d_latency got=%0d want=9", m, lat); end
      total++; if (res !== want[m]) begin bad++; $display("[TB] FAIL mode%0d_ramp got=%0d want=%0d", m, res, want[m]); end
      take_output();
    end
  endtask

  task automatic test_saturated();
    int lat; logic [PIX_W-1:0] res; logic rdy;
    send_window(ones, 2'd0, lat, res, rdy);
    total++; if (lat !== 26) begin bad++; $display("[TB] FAIL sat_mean_latency got=%0d want=26", lat); end
    total++; if (res !== 10'h3FF) begin bad++; $display("[TB] FAIL sat_mean got=%0d want=1023", res); end
    take_output();
    send_window(zeros, 2'd1, lat, res, rdy);
    total++; if (res !== 10'd0) begin bad++; $display("[TB] FAIL zero_max got=%0d want=0", res); end
    take_output();
  endtask

  task automatic test_backpressure();
    int lat; logic [PIX_W-1:0] res; logic rdy;
    send_window(ramp, 2'd1, lat, res, rdy);
    total++; if (res !== 10'd80) begin bad++; $display("[TB] FAIL bp_result got=%0d want=80", res); end
    data_bus = zeros;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out !== 10'd80 || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold cycle=%0d got valid=%b out=%0d ready=%b want valid=1 out=80 ready=0", c, out_valid, out, in_ready);
      end
    end
    in_valid = 1'b0;
    take_output();
    total++; if (out !== 10'd80 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got out=%0d busy=%b want out=80 busy=0", out, busy); end
  endtask

  task automatic test_refresh_div();
    int lat; logic [PIX_W-1:0] res; logic rdy; logic seen;
    data_bus = ramp;
    mode     = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL refresh_in_div got busy=%b valid=%b want busy=1 valid=0", busy, out_valid); end
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL refresh_idle got busy=%b ready=%b want busy=0 ready=1", busy, in_ready); end
    total++; if (out !== 10'd0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL refresh_out got out=%0d valid=%b want out=0 valid=0", out, out_valid); end
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL refresh_no_valid got=%b want=0", seen); end
    send_window(ramp, 2'd3, lat, res, rdy);
    total++; if (lat !== 9 || res !== 10'd40) begin bad++; $display("[TB] FAIL refresh_next got lat=%0d out=%0d want lat=9 out=40", lat, res); end
    take_output();
  endtask

  task automatic test_reset_mid_accum();
    logic seen;
    data_bus = ramp;
    mode     = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    total++; if (out !== 10'd0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_out got out=%0d valid=%b want out=0 valid=0", out, out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", in_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_valid got=%b want=0", seen); end
  endtask

  task automatic test_refresh_accept();
    logic seen;
    data_bus = ramp;
    mode     = 2'd3;
    in_valid = 1'b1;
    refresh  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    refresh  = 1'b0;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL refresh_accept got busy=%b ready=%b want busy=0 ready=1", busy, in_ready); end
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL refresh_accept_valid got=%b want=0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [PIX_W-1:0] res; logic rdy;
    send_window(ones, 2'd3, lat, res, rdy);
    total++; if (res !== 10'h3FF) begin bad++; $display("[TB] FAIL b2b_first got=%0d want=1023", res); end
    take_output();
    send_window(ramp, 2'd2, lat, res, rdy);
    total++; if (lat !== 9 || res !== 10'd0) begin bad++; $display("[TB] FAIL b2b_second got lat=%0d out=%0d want lat=9 out=0", lat, res); end
    take_output();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ramp[i*PIX_W +: PIX_W]  = PIX_W'(i);
      ones[i*PIX_W +: PIX_W]  = '1;
      zeros[i*PIX_W +: PIX_W] = '0;
    end
    test_reset();
    test_mean_ramp();
    test_modes_ramp();
    test_saturated();
    test_backpressure();
    test_refresh_div();
    test_reset_mid_accum();
    test_refresh_accept();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
